lsu_mem_stage: RTL and testbench

- Load/store unit sitting directly downstream of the ALU in the RV32I core.
- Takes the ALU result as the effective address and RS2 as store data.
- Runs one data-memory transaction over a valid/ready bus, aligns and extends load data, and returns it for register write-back.
- Holds the core with a stall signal while a transaction is in flight.

---
 rtl/lsu_mem_stage.sv | 183 ++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// RV32I load/store unit: runs one data-memory access per request over a valid/ready bus
// and returns aligned, extended load data for write-back. Stalls the core while busy.
module lsu_mem_stage #(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_addr,
    output logic [31:0]       wb_data,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    localparam logic [1:0] E_NONE     = 2'b00;
    localparam logic [1:0] E_MISALIGN = 2'b01;
    localparam logic [1:0] E_ILLEGAL  = 2'b10;
    localparam logic [1:0] E_TIMEOUT  = 2'b11;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [1:0]        code_q;
    logic [15:0]       cnt_q;

    logic              accept;
    logic              illegal;
    logic              misaligned;
    logic [1:0]        req_code;
    logic [3:0]        req_wstrb;
    logic [31:0]       req_lane_data;
    logic [31:0]       shifted;
    logic [31:0]       load_data;

    assign req_ready = (state == S_IDLE);
    assign stall     = (state != S_IDLE);
    assign mem_valid = (state == S_BUS);
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_we    = we_q;
    assign mem_wstrb = wstrb_q;
    assign mem_wdata = wdata_q;

    assign accept = req_valid && (state == S_IDLE);

    // Illegal encodings are reported ahead of misalignment.
    always_comb begin
        illegal    = req_we ? (req_funct3 > 3'd2)
                            : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        if (illegal)
            req_code = E_ILLEGAL;
        else if (misaligned)
            req_code = E_MISALIGN;
        else
            req_code = E_NONE;
    end

    always_comb begin
        req_wstrb     = 4'b0000;
        req_lane_data = 32'd0;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    req_wstrb     = 4'b0001 << req_addr[1:0];
                    req_lane_data = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    req_wstrb     = 4'b0011 << req_addr[1:0];
                    req_lane_data = {2{req_wdata[15:0]}};
                end
                default: begin
                    req_wstrb     = 4'b1111;
                    req_lane_data = req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        shifted = rdata_q >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    load_data = {24'd0, shifted[7:0]};
            3'd5:    load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            rd_q     <= 5'd0;
            wstrb_q  <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            code_q   <= E_NONE;
            cnt_q    <= 16'd0;
            wb_valid <= 1'b0;
            wb_addr  <= 5'd0;
            wb_data  <= 32'd0;
            err      <= 1'b0;
            err_code <= 2'b00;
            err_addr <= '0;
        end else begin
            wb_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q   <= req_addr;
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        rd_q     <= req_rd;
                        wstrb_q  <= req_wstrb;
                        wdata_q  <= req_lane_data;
                        code_q   <= req_code;
                        cnt_q    <= 16'd0;
                        state    <= (req_code == E_NONE) ? S_BUS : S_RESP;
                    end
                end
                // A ready arriving on the last allowed cycle still completes normally.
                S_BUS: begin
                    if (mem_ready) begin
                        rdata_q <= mem_rdata;
                        state   <= S_RESP;
                    end else if (cnt_q == TO_LAST) begin
                        code_q <= E_TIMEOUT;
                        state  <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    if (code_q != E_NONE) begin
                        err      <= 1'b1;
                        err_code <= code_q;
                        err_addr <= addr_q;
                    end else if (!we_q && (rd_q != 5'd0)) begin
                        wb_valid <= 1'b1;
                        wb_addr  <= rd_q;
                        wb_data  <= load_data;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage with TIMEOUT=4: stores, loads with wait
// states, alignment/illegal errors, bus timeout and asynchronous reset mid-access.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        stall;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] err_addr;

    int checks = 0;
    int errors = 0;

    int          mv_cnt;
    int          st_cnt;
    int          wb_cyc;
    int          err_cyc;
    int          wb_cnt;
    int          err_cnt;
    logic        unstable;
    logic [31:0] seen_addr;
    logic        seen_we;
    logic [3:0]  seen_wstrb;
    logic [31:0] seen_wdata;

    lsu_mem_stage #(.TIMEOUT(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .stall(stall),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .err(err), .err_code(err_code), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one request, then plays a memory that raises ready after `waits` wait cycles.
    // Edge counts are measured from the accepting edge.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input logic [31:0] rdata, input int waits);
        mv_cnt = 0; st_cnt = 0; wb_cyc = -1; err_cyc = -1; wb_cnt = 0; err_cnt = 0;
        unstable = 1'b0;
        seen_addr = 32'd0; seen_we = 1'b0; seen_wstrb = 4'd0; seen_wdata = 32'd0;
        mem_rdata = rdata;
        mem_ready = 1'b0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
        req_wdata = wd; req_rd = rd;
        tick;
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'd7; req_addr = 32'hFFFF_FFFF;
        req_wdata = 32'h5555_5555; req_rd = 5'd31;
        for (int n = 1; n <= 12; n++) begin
            if (mem_valid) begin
                mv_cnt++;
                if (mv_cnt == 1) begin
                    seen_addr = mem_addr; seen_we = mem_we;
                    seen_wstrb = mem_wstrb; seen_wdata = mem_wdata;
                end else if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !==
                             {seen_addr, seen_we, seen_wstrb, seen_wdata}) begin
                    unstable = 1'b1;
                end
            end
            if (stall) st_cnt++;
            if (wb_valid) begin
                wb_cnt++;
                if (wb_cyc < 0) wb_cyc = n - 1;
            end
            if (err) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = n - 1;
            end
            mem_ready = mem_valid && (mv_cnt > waits);
            tick;
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({req_ready, stall, mem_valid, wb_valid, err} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 10000", {req_ready, stall, mem_valid, wb_valid, err});
        end
        checks++;
        if ({mem_addr, mem_we, mem_wstrb, mem_wdata, wb_addr, wb_data, err_code, err_addr} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data got addr=%h wstrb=%b wdata=%h wb=%h err_addr=%h want all 0",
                     mem_addr, mem_wstrb, mem_wdata, wb_data, err_addr);
        end
        tick;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_store_word;
        run_req(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 5'd3, 32'd0, 0);
        checks++;
        if ({seen_addr, seen_we, seen_wstrb, seen_wdata} !== {32'h100, 1'b1, 4'b1111, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL sw_bus got addr=%h we=%b wstrb=%b wdata=%h want 00000100 1 1111 deadbeef",
                     seen_addr, seen_we, seen_wstrb, seen_wdata);
        end
        checks++;
        if (mv_cnt !== 1 || st_cnt !== 2 || wb_cnt !== 0 || err_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL sw_timing got mv=%0d stall=%0d wb=%0d err=%0d want 1 2 0 0",
                     mv_cnt, st_cnt, wb_cnt, err_cnt);
        end
    endtask

    task automatic test_store_lanes;
        run_req(1'b1, 3'd1, 32'h42, 32'h0000_ABCD, 5'd0, 32'd0, 0);
        checks++;
        if ({seen_addr, seen_wstrb, seen_wdata} !== {32'h40, 4'b1100, 32'hABCD_ABCD}) begin
            errors++;
            $display("[TB] FAIL sh_lanes got addr=%h wstrb=%b wdata=%h want 00000040 1100 abcdabcd",
                     seen_addr, seen_wstrb, seen_wdata);
        end
        run_req(1'b1, 3'd0, 32'h201, 32'h1234_5678, 5'd0, 32'd0, 1);
        checks++;
        if ({seen_addr, seen_wstrb, seen_wdata, unstable} !== {32'h200, 4'b0010, 32'h7878_7878, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sb_lanes got addr=%h wstrb=%b wdata=%h unstable=%b want 00000200 0010 78787878 0",
                     seen_addr, seen_wstrb, seen_wdata, unstable);
        end
    endtask

    task automatic test_load_byte;
        run_req(1'b0, 3'd0, 32'h203, 32'd0, 5'd5, 32'h80FF_1234, 3);
        checks++;
        if (wb_cyc !== 5 || wb_cnt !== 1 || mv_cnt !== 4) begin
            errors++;
            $display("[TB] FAIL lb_latency got wb_cyc=%0d wb_cnt=%0d mv=%0d want 5 1 4", wb_cyc, wb_cnt, mv_cnt);
        end
        checks++;
        if ({wb_addr, wb_data, seen_we, seen_wstrb} !== {5'd5, 32'hFFFF_FF80, 1'b0, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL lb_data got rd=%0d data=%h we=%b wstrb=%b want 5 ffffff80 0 0000",
                     wb_addr, wb_data, seen_we, seen_wstrb);
        end
        run_req(1'b0, 3'd4, 32'h203, 32'd0, 5'd5, 32'h80FF_1234, 3);
        checks++;
        if (wb_data !== 32'h0000_0080 || wb_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL lbu_data got %h cnt=%0d want 00000080 1", wb_data, wb_cnt);
        end
    endtask

    task automatic test_load_half_word;
        run_req(1'b0, 3'd1, 32'h202, 32'd0, 5'd9, 32'h80FF_1234, 0);
        checks++;
        if ({wb_addr, wb_data} !== {5'd9, 32'hFFFF_80FF} || wb_cyc !== 2) begin
            errors++;
            $display("[TB] FAIL lh_data got rd=%0d data=%h cyc=%0d want 9 ffff80ff 2", wb_addr, wb_data, wb_cyc);
        end
        run_req(1'b0, 3'd5, 32'h202, 32'd0, 5'd10, 32'h80FF_1234, 0);
        checks++;
        if ({wb_addr, wb_data} !== {5'd10, 32'h0000_80FF}) begin
            errors++;
            $display("[TB] FAIL lhu_data got rd=%0d data=%h want 10 000080ff", wb_addr, wb_data);
        end
        run_req(1'b0, 3'd2, 32'h200, 32'd0, 5'd11, 32'h80FF_1234, 1);
        checks++;
        if ({wb_addr, wb_data} !== {5'd11, 32'h80FF_1234} || wb_cyc !== 3) begin
            errors++;
            $display("[TB] FAIL lw_data got rd=%0d data=%h cyc=%0d want 11 80ff1234 3", wb_addr, wb_data, wb_cyc);
        end
    endtask

    task automatic test_errors;
        run_req(1'b0, 3'd2, 32'h102, 32'd0, 5'd4, 32'h1111_1111, 0);
        checks++;
        if (mv_cnt !== 0 || err_cyc !== 1 || err_cnt !== 1 || wb_cnt !== 0 || st_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL misalign_timing got mv=%0d err_cyc=%0d err_cnt=%0d wb=%0d stall=%0d want 0 1 1 0 1",
                     mv_cnt, err_cyc, err_cnt, wb_cnt, st_cnt);
        end
        checks++;
        if ({err_code, err_addr} !== {2'b01, 32'h102}) begin
            errors++;
            $display("[TB] FAIL misalign_code got code=%b addr=%h want 01 00000102", err_code, err_addr);
        end
        run_req(1'b1, 3'd3, 32'h101, 32'h1, 5'd0, 32'd0, 0);
        checks++;
        if ({err_code, err_addr} !== {2'b10, 32'h101} || mv_cnt !== 0 || err_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL illegal_store got code=%b addr=%h mv=%0d err=%0d want 10 00000101 0 1",
                     err_code, err_addr, mv_cnt, err_cnt);
        end
        run_req(1'b0, 3'd6, 32'h100, 32'd0, 5'd2, 32'd0, 0);
        checks++;
        if (err_code !== 2'b10 || mv_cnt !== 0 || wb_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL illegal_load got code=%b mv=%0d wb=%0d want 10 0 0", err_code, mv_cnt, wb_cnt);
        end
    endtask

    task automatic test_timeout;
        run_req(1'b0, 3'd2, 32'h300, 32'd0, 5'd7, 32'h1122_3344, 99);
        checks++;
        if (mv_cnt !== 4 || err_cyc !== 5 || wb_cnt !== 0 || unstable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_timing got mv=%0d err_cyc=%0d wb=%0d unstable=%b want 4 5 0 0",
                     mv_cnt, err_cyc, wb_cnt, unstable);
        end
        checks++;
        if ({err_code, err_addr} !== {2'b11, 32'h300}) begin
            errors++;
            $display("[TB] FAIL timeout_code got code=%b addr=%h want 11 00000300", err_code, err_addr);
        end
        run_req(1'b0, 3'd2, 32'h300, 32'd0, 5'd7, 32'h1122_3344, 3);
        checks++;
        if (err_cnt !== 0 || wb_cyc !== 5 || {wb_addr, wb_data} !== {5'd7, 32'h1122_3344}) begin
            errors++;
            $display("[TB] FAIL ready_on_last got err=%0d wb_cyc=%0d rd=%0d data=%h want 0 5 7 11223344",
                     err_cnt, wb_cyc, wb_addr, wb_data);
        end
    endtask

    task automatic test_rd_zero;
        run_req(1'b0, 3'd2, 32'h400, 32'd0, 5'd0, 32'hCAFE_F00D, 0);
        checks++;
        if (mv_cnt !== 1 || wb_cnt !== 0 || err_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL lw_rd0 got mv=%0d wb=%0d err=%0d want 1 0 0", mv_cnt, wb_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid_bus;
        mem_ready = 1'b0;
        mem_rdata = 32'h7777_7777;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h500; req_rd = 5'd6;
        tick;
        req_valid = 1'b0;
        tick;
        checks++;
        if ({mem_valid, stall} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL pre_reset_bus got valid/stall=%b want 11", {mem_valid, stall});
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_valid, stall, req_ready} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL async_reset got valid/stall/ready=%b want 001", {mem_valid, stall, req_ready});
        end
        tick;
        rst = 1'b1;
        wb_cnt = 0; err_cnt = 0; mv_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            if (wb_valid) wb_cnt++;
            if (err) err_cnt++;
            if (mem_valid) mv_cnt++;
            tick;
        end
        checks++;
        if (wb_cnt !== 0 || err_cnt !== 0 || mv_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL post_reset_quiet got wb=%0d err=%0d mv=%0d want 0 0 0", wb_cnt, err_cnt, mv_cnt);
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_store_word;
        test_store_lanes;
        test_load_byte;
        test_load_half_word;
        test_errors;
        test_timeout;
        test_rd_zero;
        test_reset_mid_bus;
        test_store_word;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
